// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for one stepper axis.
// A move request latches direction, period and step count. The direction is
// held for DIR_SETUP cycles before the first step. Then exactly `steps` pulses
// are emitted, each PULSE_W cycles high, one every period_eff cycles.
// A start/busy/done handshake reports completion. An abort request ends the
// move early but never truncates a pulse that is already high.
module step_pulse_gen #(
  parameter int PER_W     = 16,
  parameter int CNT_W     = 16,
  parameter int PULSE_W   = 2,
  parameter int DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir_in,
  input  logic [PER_W-1:0] period,
  input  logic [CNT_W-1:0] steps,
  input  logic             abort,
  output logic             step_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  // Phase counter width: large enough for any period, setup or pulse length.
  localparam int CW_A = (PER_W > DIR_SETUP) ? PER_W : DIR_SETUP;
  localparam int CW   = (CW_A > PULSE_W) ? CW_A : PULSE_W;

  localparam logic [CW-1:0]    CW_ZERO    = CW'(0);
  localparam logic [CW-1:0]    CW_ONE     = CW'(1);
  localparam logic [CW-1:0]    SETUP_LOAD = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0]    HIGH_LOAD  = CW'(PULSE_W - 1);
  // The shortest legal period leaves at least one low cycle between pulses.
  localparam logic [PER_W-1:0] PER_MIN    = PER_W'(PULSE_W + 1);
  localparam logic [CNT_W-1:0] LEFT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] LEFT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [PER_W-1:0] period_eff_r;
  logic             abort_pend_r;
  logic             step_r;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;
  logic [CNT_W-1:0] steps_left_r;

  logic [PER_W-1:0] period_eff_s;
  logic [CW-1:0]    low_load_s;
  logic [CW-1:0]    cnt_dec_s;
  logic [CNT_W-1:0] left_dec_s;
  logic             cnt_zero_s;

  // Derived values: clamped period, LOW reload, and decremented counters.
  always_comb begin
    period_eff_s = period;
    if (period < PER_MIN) begin
      period_eff_s = PER_MIN;
    end else begin
      period_eff_s = period;
    end
    // LOW lasts period_eff - PULSE_W cycles; the counter runs down to zero.
    low_load_s = CW'(period_eff_r - PER_MIN);
    cnt_dec_s  = cnt_r - CW_ONE;
    left_dec_s = steps_left_r - LEFT_ONE;
    cnt_zero_s = (cnt_r == CW_ZERO);
  end

  // Move sequencer: state, phase counter, and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CW_ZERO;
      period_eff_r <= PER_MIN;
      abort_pend_r <= 1'b0;
      step_r       <= 1'b0;
      dir_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      steps_left_r <= LEFT_ZERO;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          step_r       <= 1'b0;
          abort_pend_r <= 1'b0;
          if (start) begin
            if (steps != LEFT_ZERO) begin
              period_eff_r <= period_eff_s;
              dir_r        <= dir_in;
              busy_r       <= 1'b1;
              steps_left_r <= steps;
              cnt_r        <= SETUP_LOAD;
              state_r      <= ST_SETUP;
            end else begin
              // Zero-length move: acknowledge immediately, touch nothing else.
              done_r <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (abort) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else if (cnt_zero_s) begin
            step_r  <= 1'b1;
            cnt_r   <= HIGH_LOAD;
            state_r <= ST_HIGH;
          end else begin
            cnt_r <= cnt_dec_s;
          end
        end
        ST_HIGH: begin
          if (cnt_zero_s) begin
            // Falling edge: the step counts as completed even when aborting.
            step_r       <= 1'b0;
            steps_left_r <= left_dec_s;
            abort_pend_r <= 1'b0;
            if (abort || abort_pend_r) begin
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              aborted_r <= 1'b1;
            end else begin
              cnt_r   <= low_load_s;
              state_r <= ST_LOW;
            end
          end else begin
            cnt_r <= cnt_dec_s;
            // Remember an abort seen mid-pulse; honour it at the falling edge.
            if (abort) begin
              abort_pend_r <= 1'b1;
            end else begin
              abort_pend_r <= abort_pend_r;
            end
          end
        end
        ST_LOW: begin
          if (cnt_zero_s && (steps_left_r == LEFT_ZERO)) begin
            // Normal end takes priority over a coincident abort.
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b0;
          end else if (abort) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            aborted_r <= 1'b1;
          end else if (cnt_zero_s) begin
            step_r  <= 1'b1;
            cnt_r   <= HIGH_LOAD;
            state_r <= ST_HIGH;
          end else begin
            cnt_r <= cnt_dec_s;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          step_r       <= 1'b0;
          busy_r       <= 1'b0;
          abort_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign step_out   = step_r;
  assign dir_out    = dir_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;
  assign steps_left = steps_left_r;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen. A move-level model (pulse times computed from
// period/count arithmetic) is compared against the DUT on every negedge.
// Literal checks pin key timing points.
module tb_step_pulse_gen;

  localparam int PER_W     = 16;
  localparam int CNT_W     = 16;
  localparam int PULSE_W   = 2;
  localparam int DIR_SETUP = 4;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             start  = 1'b0;
  logic             dir_in = 1'b0;
  logic [PER_W-1:0] period = '0;
  logic [CNT_W-1:0] steps  = '0;
  logic             abort  = 1'b0;
  logic             step_out, dir_out, busy, done, aborted;
  logic [CNT_W-1:0] steps_left;

  step_pulse_gen #(
    .PER_W(PER_W), .CNT_W(CNT_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir_in(dir_in),
    .period(period), .steps(steps), .abort(abort),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left)
  );

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Edge counter: after rising edge number c, cyc == c.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit valid; int e0; int p; int n; int ab; bit dir; bit base_dir; int base_left;
  } move_t;
  typedef struct { bit st; bit bu; bit dn; bit ab; bit dr; int left; } exp_t;

  move_t cur_m = '{default: 0};
  move_t prev_m = '{default: 0};

  task automatic chk(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  // Expected outputs r edges after e0, from the pulse timetable of the move.
  function automatic exp_t eval_move(move_t m, int r);
    exp_t x;
    int end_t, t, k, o, falls, rise;
    bit abt;
    x = '{default: 0};
    abt = 1'b0;
    if (m.n == 0) end_t = 0;
    else end_t = DIR_SETUP + m.n * m.p;
    if (m.n != 0 && m.ab > 0 && m.ab <= end_t) begin
      if (m.ab <= DIR_SETUP) begin
        end_t = m.ab; abt = 1'b1;
      end else begin
        t = m.ab - 1 - DIR_SETUP;
        k = t / m.p;
        o = t % m.p;
        if (o < PULSE_W) begin
          end_t = DIR_SETUP + k * m.p + PULSE_W; abt = 1'b1;
        end else if (m.ab != end_t) begin
          end_t = m.ab; abt = 1'b1;
        end
      end
    end
    falls = 0;
    for (int i = 0; i < m.n; i++) begin
      rise = DIR_SETUP + i * m.p;
      if (rise + PULSE_W <= r && rise + PULSE_W <= end_t) falls++;
      if (rise < end_t && rise <= r && r < rise + PULSE_W) x.st = 1'b1;
    end
    x.bu   = (r < end_t);
    x.dn   = (r == end_t);
    x.ab   = x.dn && abt;
    x.dr   = (m.n == 0) ? m.base_dir : m.dir;
    x.left = (m.n == 0) ? m.base_left : m.n - falls;
    return x;
  endfunction

  function automatic exp_t expect_now(int c);
    exp_t x;
    x = '{default: 0};
    if (cur_m.valid && c >= cur_m.e0) x = eval_move(cur_m, c - cur_m.e0);
    else if (prev_m.valid) x = eval_move(prev_m, c - prev_m.e0);
    return x;
  endfunction

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_en) begin
      e = expect_now(cyc);
      chk("step_out",   int'(step_out),   int'(e.st));
      chk("busy",       int'(busy),       int'(e.bu));
      chk("done",       int'(done),       int'(e.dn));
      chk("aborted",    int'(aborted),    int'(e.ab));
      chk("dir_out",    int'(dir_out),    int'(e.dr));
      chk("steps_left", int'(steps_left), e.left);
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    for (int i = 0; i < 1000 && cyc < c; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_until", cyc, c);
  endtask

  // Issue a move; called just after a rising edge, e0 is the next edge.
  task automatic start_move(bit d, int per, int n, int ab_rel);
    exp_t b;
    b = expect_now(cyc);
    prev_m = cur_m;
    cur_m.valid = 1'b1;
    cur_m.e0 = cyc + 1;
    cur_m.p = (per < PULSE_W + 1) ? PULSE_W + 1 : per;
    cur_m.n = n;
    cur_m.ab = ab_rel;
    cur_m.dir = d;
    cur_m.base_dir = b.dr;
    cur_m.base_left = b.left;
    start = 1'b1; dir_in = d; period = PER_W'(per); steps = CNT_W'(n);
    @(posedge clk);
    #1;
    start = 1'b0; dir_in = ~d; period = PER_W'(7); steps = CNT_W'(9);
    if (ab_rel > 0) begin
      repeat (ab_rel - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
  endtask

  task automatic run_s1();
    start_move(1'b1, 10, 3, 0);
    for (int r = 0; r <= 35; r++) begin
      @(negedge clk);
      case (r)
        0:  begin chk("s1_dir_e0", int'(dir_out), 1); chk("s1_busy_e0", int'(busy), 1); end
        3:  chk("s1_step_e3", int'(step_out), 0);
        4:  chk("s1_rise_e4", int'(step_out), 1);
        6:  begin chk("s1_fall_e6", int'(step_out), 0); chk("s1_left_e6", int'(steps_left), 2); end
        14: chk("s1_rise_e14", int'(step_out), 1);
        16: chk("s1_left_e16", int'(steps_left), 1);
        24: chk("s1_rise_e24", int'(step_out), 1);
        26: chk("s1_left_e26", int'(steps_left), 0);
        33: chk("s1_done_e33", int'(done), 0);
        34: begin
          chk("s1_done_e34", int'(done), 1);
          chk("s1_busy_e34", int'(busy), 0);
          chk("s1_abrt_e34", int'(aborted), 0);
        end
        35: chk("s1_done_e35", int'(done), 0);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_step_out", int'(step_out), 0);
    chk("rst_dir_out", int'(dir_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_steps_left", int'(steps_left), 0);
    wait_cycles(2);

    // Nominal move.
    run_s1();
    wait_cycles(3);

    // Zero-step move: done only, dir_out keeps 1.
    start_move(1'b0, 10, 0, 0);
    @(negedge clk);
    chk("s2_done", int'(done), 1);
    chk("s2_busy", int'(busy), 0);
    chk("s2_dir_kept", int'(dir_out), 1);
    @(negedge clk);
    chk("s2_done_once", int'(done), 0);
    @(posedge clk);
    #1;
    wait_cycles(2);

    // Period clamp: 1 -> 3.
    start_move(1'b0, 1, 2, 0);
    for (int r = 0; r <= 11; r++) begin
      @(negedge clk);
      case (r)
        4:  chk("s3_rise_e4", int'(step_out), 1);
        6:  chk("s3_low_e6", int'(step_out), 0);
        7:  chk("s3_rise_e7", int'(step_out), 1);
        10: chk("s3_done_e10", int'(done), 1);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    wait_cycles(2);

    // Abort in LOW of step 0.
    start_move(1'b1, 10, 5, 10);
    @(negedge clk);
    chk("s4a_done", int'(done), 1);
    chk("s4a_aborted", int'(aborted), 1);
    chk("s4a_left", int'(steps_left), 4);
    @(posedge clk);
    #1;
    wait_cycles(3);

    // Abort in HIGH: pulse completes.
    start_move(1'b1, 10, 5, 15);
    @(negedge clk);
    chk("s4b_high_e15", int'(step_out), 1);
    chk("s4b_nodone_e15", int'(done), 0);
    @(negedge clk);
    chk("s4b_fall_e16", int'(step_out), 0);
    chk("s4b_done_e16", int'(done), 1);
    chk("s4b_aborted", int'(aborted), 1);
    chk("s4b_left", int'(steps_left), 3);
    @(posedge clk);
    #1;
    wait_cycles(3);

    // Abort coincident with final LOW end: normal completion.
    start_move(1'b0, 10, 2, 24);
    @(negedge clk);
    chk("s4c_done", int'(done), 1);
    chk("s4c_not_aborted", int'(aborted), 0);
    @(posedge clk);
    #1;
    wait_cycles(2);

    // Abort in SETUP.
    start_move(1'b1, 6, 4, 2);
    @(negedge clk);
    chk("s4d_done", int'(done), 1);
    chk("s4d_aborted", int'(aborted), 1);
    chk("s4d_left", int'(steps_left), 4);
    @(posedge clk);
    #1;
    wait_cycles(2);

    // Abort while idle is ignored.
    abort = 1'b1;
    wait_cycles(2);
    abort = 1'b0;
    wait_cycles(2);

    // Inputs toggled while busy, then back-to-back start on done.
    start_move(1'b1, 10, 3, 0);
    wait_cycles(8);
    start = 1'b1; dir_in = 1'b0; period = PER_W'(3); steps = CNT_W'(7);
    wait_cycles(3);
    chk("s5_dir_held", int'(dir_out), 1);
    chk("s5_busy_held", int'(busy), 1);
    start = 1'b0; dir_in = 1'b1;
    wait_until(cur_m.e0 + 34);
    chk("s5_done_cycle", int'(done), 1);
    start_move(1'b0, 10, 1, 0);
    @(negedge clk);
    chk("s5_b2b_busy", int'(busy), 1);
    chk("s5_b2b_dir", int'(dir_out), 0);
    chk("s5_b2b_left", int'(steps_left), 1);
    @(posedge clk);
    #1;
    wait_cycles(18);

    // Asynchronous reset during HIGH.
    start_move(1'b1, 10, 3, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("s6_pre_high", int'(step_out), 1);
    #1 rst_n = 1'b0;
    cur_m.valid = 1'b0;
    prev_m.valid = 1'b0;
    #1;
    chk("s6_rst_step", int'(step_out), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_left", int'(steps_left), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);
    run_s1();
    wait_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
